operand_fetch_stage: RTL
========================

Name: operand_fetch_stage

Overview:
- Decode/operand-fetch pipeline stage sitting directly upstream of the RS1/RD operand mux.
- Splits the 32-bit instruction word into its fields and holds the 32x32 architectural register file.
- Reads source operands with writeback bypass and registers OPC, RS1, RS2, RD_in and the immediate for the mux and ALU.
- Supports stall, which holds the stage, and flush, which squashes it for JUMP/BRA redirect.

Parameters:
- NREGS, 32: number of architectural registers; R0 is hardwired to zero.
- DW, 32: data and instruction width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  instr carries a valid instruction this cycle.
- instr  in  32  instruction word: [31:26] opc, [25:21] rd, [20:16] rs1, [15:11] rs2, [15:0] imm16.
- stall  in  1  downstream not ready; hold the stage.
- flush  in  1  squash the stage (taken JUMP/BRA).
- wb_en  in  1  register write enable.
- wb_addr  in  5  register write index.
- wb_data  in  32  register write data.
- out_valid  out  1  output fields are a valid instruction.
- OPC  out  6  decoded opcode, NOP when invalid.
- RS1  out  32  value of register rs1.
- RS2  out  32  value of register rs2.
- RD_in  out  32  value of register rd (store data).
- imm  out  32  extended immediate.
- rd_addr  out  5  destination register index.
- illegal  out  1  opcode above BRA (6'b010110) was captured; converted to NOP.

Behaviour:
- Reset, synchronous at the clock edge:
  - out_valid=0, OPC=NOP (0), illegal=0.
  - RS1, RS2, RD_in, imm, rd_addr = 0.
  - All NREGS registers cleared to 0.
  - Reset overrides every other input.
- Register file writes:
  - At the edge, if wb_en=1 and wb_addr!=0, reg[wb_addr]<=wb_data.
  - Writes to R0 are ignored.
  - Writes occur regardless of stall or flush.
- Update priority per edge, after reset: flush > stall > capture.
- Flush:
  - out_valid<=0, OPC<=NOP, illegal<=0; other outputs hold.
  - instr is discarded even if instr_valid=1.
- Stall (and no flush):
  - All outputs hold and instr is not consumed; upstream must hold instr.
  - Held-operand refresh: if wb_en=1, wb_addr!=0 and wb_addr equals the stored rs1, rs2 or rd index, the matching RS1/RS2/RD_in output is updated to wb_data.
  - Stored source indices are kept internally for this comparison.
- Capture (no stall, no flush, instr_valid=1):
  - Latency is one cycle: fields appear on the outputs the edge after capture.
  - Each operand reads reg[idx]. Bypass: if wb_en=1 and wb_addr==idx!=0 in the same cycle, wb_data is used. Index 0 always yields 0.
  - rd_addr<=instr[25:21]; out_valid<=1.
  - opc>6'b010110: OPC<=NOP, illegal<=1, out_valid<=1; illegal is otherwise 0.
- No stall, no flush, instr_valid=0: out_valid<=0, OPC<=NOP, illegal<=0.
- Immediate extension:
  - Sign-extend imm16 for ADDI, SUBI, JUMP, BRA.
  - Zero-extend imm16 for MOVEI, SLI, SRI.
  - imm=0 for all other opcodes.
- OPC output is always a legal opcode in 0..22; the downstream mux never sees undefined opcodes.

Test Plan:
1. Reset, then write R5=0x0000_1234 via wb; capture ADD rd=3, rs1=5, rs2=0 -> next cycle out_valid=1, OPC=6'b000001, RS1=0x1234, RS2=0, rd_addr=3.
2. Same-cycle bypass: wb_en=1, wb_addr=7, wb_data=0xDEADBEEF while capturing STORE rd=7, rs1=2 -> RD_in=0xDEADBEEF; R7 reads 0xDEADBEEF afterwards.
3. Stall with refresh: hold LOAD rs1=9 (R9=0x10) stalled 3 cycles; write R9=0x20 during cycle 2 -> RS1 changes to 0x20, out_valid stays 1, other fields unchanged.
4. Flush with stall and instr_valid both 1 -> next cycle out_valid=0, OPC=0; R0 write of 0xFFFF_FFFF ignored, a later read of R0 gives 0.
5. Immediates: ADDI imm16=0xFFFE -> imm=0xFFFF_FFFE; MOVEI imm16=0xFFFE -> imm=0x0000_FFFE; opc=6'b111111 -> OPC=0, illegal=1 for one cycle.
6. Mid-stream reset: assert reset for one cycle while out_valid=1 and a wb is pending -> outputs zero, out_valid=0, pending write lost, all registers read 0.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Decode / operand-fetch stage: field split, 32x32 register file,
// writeback bypass and registered operands for the operand mux and ALU.
module operand_fetch_stage #(
  parameter int NREGS = 32,
  parameter int DW    = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          instr_valid,
  input  logic [DW-1:0] instr,
  input  logic          stall,
  input  logic          flush,
  input  logic          wb_en,
  input  logic [4:0]    wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  output logic [5:0]    OPC,
  output logic [DW-1:0] RS1,
  output logic [DW-1:0] RS2,
  output logic [DW-1:0] RD_in,
  output logic [DW-1:0] imm,
  output logic [4:0]    rd_addr,
  output logic          illegal
);

  localparam logic [5:0] OP_NOP   = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd9;
  localparam logic [5:0] OP_SUBI  = 6'd10;
  localparam logic [5:0] OP_MOVEI = 6'd12;
  localparam logic [5:0] OP_SLI   = 6'd13;
  localparam logic [5:0] OP_SRI   = 6'd14;
  localparam logic [5:0] OP_JUMP  = 6'd21;
  localparam logic [5:0] OP_BRA   = 6'd22;

  logic [5:0]  opc;
  logic [4:0]  rd_a;
  logic [4:0]  rs1_a;
  logic [4:0]  rs2_a;
  logic [15:0] imm16;

  assign opc   = instr[31:26];
  assign rd_a  = instr[25:21];
  assign rs1_a = instr[20:16];
  assign rs2_a = instr[15:11];
  assign imm16 = instr[15:0];

  logic [DW-1:0] rf_q [NREGS];
  logic [DW-1:0] rf_d [NREGS];

  logic          valid_q, valid_d;
  logic [5:0]    opc_q, opc_d;
  logic [DW-1:0] rs1_q, rs1_d;
  logic [DW-1:0] rs2_q, rs2_d;
  logic [DW-1:0] rdv_q, rdv_d;
  logic [DW-1:0] imm_q, imm_d;
  logic [4:0]    rd_addr_q, rd_addr_d;
  logic          illegal_q, illegal_d;
  logic [4:0]    rs1_idx_q, rs1_idx_d;
  logic [4:0]    rs2_idx_q, rs2_idx_d;

  logic          wb_hit;
  logic          legal;
  logic          sext;
  logic          zext;
  logic [DW-1:0] rs1_rd;
  logic [DW-1:0] rs2_rd;
  logic [DW-1:0] rdv_rd;
  logic [DW-1:0] imm_ext;

  assign wb_hit = wb_en && (wb_addr != 5'd0);
  assign legal  = opc <= OP_BRA;
  assign sext   = (opc == OP_ADDI) || (opc == OP_SUBI) ||
                  (opc == OP_JUMP) || (opc == OP_BRA);
  assign zext   = (opc == OP_MOVEI) || (opc == OP_SLI) ||
                  (opc == OP_SRI);

  // Writeback in the same cycle wins over the stale file contents.
  always_comb begin
    rs1_rd = rf_q[rs1_a];
    rs2_rd = rf_q[rs2_a];
    rdv_rd = rf_q[rd_a];
    if (wb_hit && wb_addr == rs1_a) rs1_rd = wb_data;
    if (wb_hit && wb_addr == rs2_a) rs2_rd = wb_data;
    if (wb_hit && wb_addr == rd_a)  rdv_rd = wb_data;
    if (rs1_a == 5'd0) rs1_rd = '0;
    if (rs2_a == 5'd0) rs2_rd = '0;
    if (rd_a == 5'd0)  rdv_rd = '0;
  end

  always_comb begin
    imm_ext = '0;
    unique case (1'b1)
      sext:    imm_ext = {{(DW-16){imm16[15]}}, imm16};
      zext:    imm_ext = {{(DW-16){1'b0}}, imm16};
      default: imm_ext = '0;
    endcase
  end

  always_comb begin
    rf_d      = rf_q;
    valid_d   = valid_q;
    opc_d     = opc_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rdv_d     = rdv_q;
    imm_d     = imm_q;
    rd_addr_d = rd_addr_q;
    illegal_d = illegal_q;
    rs1_idx_d = rs1_idx_q;
    rs2_idx_d = rs2_idx_q;
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf_d[i] = '0;
      valid_d   = 1'b0;
      opc_d     = OP_NOP;
      rs1_d     = '0;
      rs2_d     = '0;
      rdv_d     = '0;
      imm_d     = '0;
      rd_addr_d = '0;
      illegal_d = 1'b0;
      rs1_idx_d = '0;
      rs2_idx_d = '0;
    end else begin
      if (wb_hit) rf_d[wb_addr] = wb_data;
      if (flush) begin
        valid_d   = 1'b0;
        opc_d     = OP_NOP;
        illegal_d = 1'b0;
      end else if (stall) begin
        // Keep held operands coherent with writebacks that land meanwhile.
        if (wb_hit && wb_addr == rs1_idx_q) rs1_d = wb_data;
        if (wb_hit && wb_addr == rs2_idx_q) rs2_d = wb_data;
        if (wb_hit && wb_addr == rd_addr_q) rdv_d = wb_data;
      end else if (instr_valid) begin
        valid_d   = 1'b1;
        opc_d     = legal ? opc : OP_NOP;
        illegal_d = !legal;
        rs1_d     = rs1_rd;
        rs2_d     = rs2_rd;
        rdv_d     = rdv_rd;
        imm_d     = imm_ext;
        rd_addr_d = rd_a;
        rs1_idx_d = rs1_a;
        rs2_idx_d = rs2_a;
      end else begin
        valid_d   = 1'b0;
        opc_d     = OP_NOP;
        illegal_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    rf_q      <= rf_d;
    valid_q   <= valid_d;
    opc_q     <= opc_d;
    rs1_q     <= rs1_d;
    rs2_q     <= rs2_d;
    rdv_q     <= rdv_d;
    imm_q     <= imm_d;
    rd_addr_q <= rd_addr_d;
    illegal_q <= illegal_d;
    rs1_idx_q <= rs1_idx_d;
    rs2_idx_q <= rs2_idx_d;
  end

  assign out_valid = valid_q;
  assign OPC       = opc_q;
  assign RS1       = rs1_q;
  assign RS2       = rs2_q;
  assign RD_in     = rdv_q;
  assign imm       = imm_q;
  assign rd_addr   = rd_addr_q;
  assign illegal   = illegal_q;

endmodule
